uart_controller: RTL and testbench
==================================

Name: uart_controller

Overview:
- Serialises the game's player-input state (up, down, fire, projectile) onto a single UART TX line for the host link.
- Sends one 8N1 byte whenever the synchronised input vector differs from the last value transmitted.
- Sits between the button/game-logic domain and the board's UART pin.

Parameters:
- CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200). Legal minimum is 2. Benches override it to 4.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset. Asserted (0) forces the reset state immediately.
- up  input  1  up button level, asynchronous to clk_in.
- down  input  1  down button level, asynchronous.
- fire  input  1  firing-active level, asynchronous.
- proj  input  1  projectile-present level, asynchronous.
- tx  output  1  UART serial out. Idle high, 8N1, LSB first.

Behaviour:
- Input capture: each input passes through a 2-flop synchroniser (s1, then s2); all resets to 0.
- Status vector: V = {proj, fire, down, up}.
- Frame byte: B = {4'hA, V}, so bits[7:4] are 1010 and bit0 is up.
- Register last_sent (4 bits) resets to 0000.
- FSM states are IDLE, START, DATA, STOP. Reset state is IDLE with tx=1, bit counter 0 and baud counter 0.
- IDLE:
  - tx=1.
  - If V_s2 != last_sent: on that edge load shift register with B, set last_sent=V_s2, go to START.
  - tx is registered, so it goes 0 from that edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After 8 bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: an input changed before rising edge k appears in s1 at k and s2 at k+1. The start bit begins at edge k+2 if the FSM is IDLE.
- Input changes during a frame do not disturb the frame in flight. On return to IDLE, V_s2 is compared against last_sent again:
  - The latest state only is sent; intermediate states are dropped.
  - If the inputs returned to the last-sent value, nothing is sent.
- Back-to-back frames: after STOP, at least one cycle in IDLE with tx=1 occurs before the next start bit.
- Simultaneous changes on several inputs produce one frame carrying all of them.
- Pulses of at least 2 clk_in cycles are guaranteed captured. Shorter pulses may be missed.
- Reset asserted mid-frame: tx=1 immediately (asynchronous). Frame is abandoned, last_sent=0000, synchronisers=0. After release, a nonzero input state produces a new frame.
- Reset and tx are never glitched low outside START or a DATA bit equal to 0.
- No other outputs. No receive path.
- Baud counter width is clog2(CLKS_PER_BIT).

Test Plan:
- Reset, all inputs 0, CLKS_PER_BIT=4, 10 ns clock, run 2 us -> tx stays 1 throughout; no frame.
- After reset, up=1 for 16 ns -> frame 0xA1: tx = 0,1,0,0,0,0,1,0,1,1, each level lasting 4 cycles. After stop plus at least one idle cycle, frame 0xA0 follows because up has dropped. tx is 1 afterwards.
- fire and proj both raised on the same edge and held -> exactly one frame 0xAC. No further frames while held.
- Start frame 0xA1 (up held). During its DATA phase, raise down and then drop up -> frame 0xA1 completes unchanged, then a single 0xA2 frame.
- During a frame, toggle down 0→1→0 with each level held 3 cycles and all else constant -> no additional frame after the current one.
- Assert rst low mid-DATA -> tx=1 in the same timestep without a clock edge. After release with up held 1 -> new full frame 0xA1 starting 2 edges after release.

Source files
------------

// File: rtl/uart_controller.sv
// rtl/uart_controller.sv - sends an 8N1 status byte on tx whenever synchronised player inputs change
module uart_controller #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_in,
    input  logic rst,
    input  logic up,
    input  logic down,
    input  logic fire,
    input  logic proj,
    output logic tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    last_sent;
    logic [3:0]    last_sent_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_cnt_next;
    logic          tx_next;
    logic          baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // Two-flop synchroniser; the inputs are button levels from another domain.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1 <= 4'h0;
            s2 <= 4'h0;
        end else begin
            s1 <= {proj, fire, down, up};
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_sent <= 4'h0;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            last_sent <= last_sent_next;
            shift     <= shift_next;
            bit_cnt   <= bit_cnt_next;
            baud_cnt  <= baud_cnt_next;
            tx        <= tx_next;
        end
    end

    // tx is registered, so each branch sets the level for the cycle after the edge.
    always_comb begin
        state_next     = state;
        last_sent_next = last_sent;
        shift_next     = shift;
        bit_cnt_next   = bit_cnt;
        baud_cnt_next  = baud_cnt;
        tx_next        = tx;

        case (state)
            IDLE: begin
                tx_next       = 1'b1;
                baud_cnt_next = '0;
                bit_cnt_next  = 3'd0;
                if (s2 != last_sent) begin
                    shift_next     = {4'hA, s2};
                    last_sent_next = s2;
                    tx_next        = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    tx_next       = shift[0];
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_next = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        tx_next      = 1'b1;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_controller.sv
// tb/tb_uart_controller.sv - randomized self-checking bench for uart_controller
module tb_uart_controller;

    localparam int CPB = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    logic up     = 1'b0;
    logic down   = 1'b0;
    logic fire   = 1'b0;
    logic proj   = 1'b0;
    logic tx;

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] got[$];

    logic [3:0] hist[$];
    logic [3:0] pend = 4'h0;
    logic [3:0] last_m = 4'h0;
    logic [3:0] v_m;
    int         cyc = 0;
    int         fs = 0;
    int         next_free = 0;
    bit         fvalid = 0;
    logic [7:0] fbyte = 8'h00;
    logic [9:0] frame_bits;
    logic       exp_tx;
    int         idx;

    logic [9:0] mon_bits;
    bit         mon_ok;

    uart_controller #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .up    (up),
        .down  (down),
        .fire  (fire),
        .proj  (proj),
        .tx    (tx)
    );

    always #5 clk_in = ~clk_in;

    // Reference: a frame of {stop, byte, start} bits starts on the edge where the
    // input value seen two edges earlier differs from the last byte sent, provided
    // the previous frame plus one idle cycle has elapsed.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst !== 1'b1) begin
                hist.delete();
                last_m    = 4'h0;
                fvalid    = 0;
                next_free = 0;
                cyc       = 0;
                exp_tx    = 1'b1;
            end else begin
                cyc++;
                hist.push_back(pend);
                if (hist.size() > 3) void'(hist.pop_front());
                v_m = (hist.size() == 3) ? hist[0] : 4'h0;
                if (cyc >= next_free && v_m != last_m) begin
                    fvalid    = 1;
                    fs        = cyc;
                    fbyte     = {4'hA, v_m};
                    last_m    = v_m;
                    next_free = cyc + 10 * CPB + 1;
                end
                exp_tx = 1'b1;
                if (fvalid && (cyc - fs) < 10 * CPB) begin
                    idx        = (cyc - fs) / CPB;
                    frame_bits = {1'b1, fbyte, 1'b0};
                    exp_tx     = frame_bits[idx];
                end
            end
            pend = {proj, fire, down, up};
            ncmp++;
            if (tx !== exp_tx) begin
                nerr++;
                $display("FAIL tx_cycle t=%0t cyc=%0d tx=%b expected=%b", $time, cyc, tx, exp_tx);
            end
        end
    end

    // Independent frame decoder sampling mid-bit.
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst === 1'b1 && tx === 1'b0) begin
                mon_ok   = 1;
                mon_bits = '0;
                for (int i = 1; i < 10 * CPB; i++) begin
                    @(negedge clk_in);
                    if (rst !== 1'b1) begin
                        mon_ok = 0;
                        break;
                    end
                    if (i % CPB == CPB / 2) mon_bits[i / CPB] = tx;
                end
                if (mon_ok) got.push_back(mon_bits[8:1]);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic set_v(input logic [3:0] v);
        {proj, fire, down, up} = v;
    endtask

    task automatic drain;
        set_v(4'h0);
        wait_cyc(100);
        got.delete();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_in);
        ncmp++;
        if (tx !== 1'b1) begin
            nerr++;
            $display("FAIL reset_tx got=%b want=1", tx);
        end
        #2;
        rst = 1'b1;
        wait_cyc(200);
        ncmp++;
        if (got.size() != 0) begin
            nerr++;
            $display("FAIL idle_no_frame frames=%0d want=0", got.size());
        end
        ncmp++;
        if (tx !== 1'b1) begin
            nerr++;
            $display("FAIL idle_tx got=%b want=1", tx);
        end
    endtask

    task automatic test_up_pulse;
        got.delete();
        up = 1'b1;
        #16;
        up = 1'b0;
        wait_cyc(120);
        ncmp++;
        if (got.size() != 2) begin
            nerr++;
            $display("FAIL pulse_count frames=%0d want=2", got.size());
        end else begin
            ncmp++;
            if (got[0] !== 8'hA1) begin
                nerr++;
                $display("FAIL pulse_first got=%h want=a1", got[0]);
            end
            ncmp++;
            if (got[1] !== 8'hA0) begin
                nerr++;
                $display("FAIL pulse_second got=%h want=a0", got[1]);
            end
        end
    endtask

    task automatic test_simultaneous;
        got.delete();
        fire = 1'b1;
        proj = 1'b1;
        wait_cyc(150);
        ncmp++;
        if (got.size() != 1) begin
            nerr++;
            $display("FAIL simul_count frames=%0d want=1", got.size());
        end else begin
            ncmp++;
            if (got[0] !== 8'hAC) begin
                nerr++;
                $display("FAIL simul_byte got=%h want=ac", got[0]);
            end
        end
        drain();
    endtask

    task automatic test_latest_only;
        got.delete();
        up = 1'b1;
        wait_cyc(14);
        down = 1'b1;
        wait_cyc(3);
        up = 1'b0;
        wait_cyc(140);
        ncmp++;
        if (got.size() != 2) begin
            nerr++;
            $display("FAIL latest_count frames=%0d want=2", got.size());
        end else begin
            ncmp++;
            if (got[0] !== 8'hA1) begin
                nerr++;
                $display("FAIL latest_first got=%h want=a1", got[0]);
            end
            ncmp++;
            if (got[1] !== 8'hA2) begin
                nerr++;
                $display("FAIL latest_second got=%h want=a2", got[1]);
            end
        end
        drain();
    endtask

    task automatic test_glitch_drop;
        got.delete();
        up = 1'b1;
        wait_cyc(12);
        down = 1'b1;
        wait_cyc(3);
        down = 1'b0;
        wait_cyc(100);
        ncmp++;
        if (got.size() != 1) begin
            nerr++;
            $display("FAIL glitch_count frames=%0d want=1", got.size());
        end else begin
            ncmp++;
            if (got[0] !== 8'hA1) begin
                nerr++;
                $display("FAIL glitch_byte got=%h want=a1", got[0]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_frame;
        got.delete();
        up = 1'b1;
        wait_cyc(15);
        ncmp++;
        if (tx !== 1'b0) begin
            nerr++;
            $display("FAIL midframe_bit2 got=%b want=0", tx);
        end
        #1;
        rst = 1'b0;
        #1;
        ncmp++;
        if (tx !== 1'b1) begin
            nerr++;
            $display("FAIL async_reset_tx got=%b want=1", tx);
        end
        wait_cyc(3);
        got.delete();
        @(negedge clk_in);
        #2;
        rst = 1'b1;
        wait_cyc(100);
        ncmp++;
        if (got.size() != 1) begin
            nerr++;
            $display("FAIL post_reset_count frames=%0d want=1", got.size());
        end else begin
            ncmp++;
            if (got[0] !== 8'hA1) begin
                nerr++;
                $display("FAIL post_reset_byte got=%h want=a1", got[0]);
            end
        end
        drain();
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            set_v(4'($urandom_range(0, 15)));
            wait_cyc(int'($urandom_range(1, 50)));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_up_pulse();
        test_simultaneous();
        test_latest_only();
        test_glitch_drop();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
